alu_issue_ctrl: RTL and testbench

- Command front end that sits directly upstream of the 32-bit ripple ALU.
- Accepts operation commands on a valid/ready interface and translates each opcode into the ALU's 4-bit control word {A_invert, B_invert, op[1:0]}.
- Drives the ALU operands, tracks the ALU's one-cycle registered latency, and captures result/zero/cout/overflow with the command's tag.
- Returns responses in order through a small credit-protected FIFO, so the ALU never produces a result with nowhere to go.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_rsp_fifo.sv | 66 ++++++
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: command opcodes, ALU control encodings and the buffered response record
// shared by the ALU issue front end.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;

  // {A_invert, B_invert, op[1:0]}
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        err;
  } rsp_data_t;

  function automatic logic [3:0] op_to_ctrl(input logic [2:0] op);
    logic [3:0] ctrl;
    case (op)
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_SLT:  ctrl = CTRL_SLT;
      OP_NOR:  ctrl = CTRL_NOR;
      default: ctrl = CTRL_AND;
    endcase
    return ctrl;
  endfunction

  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op > OP_NOR);
  endfunction

  // Only the adder-based operations report meaningful carry/overflow.
  function automatic logic op_has_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
`default_nettype none
// alu_rsp_fifo: first-word-fall-through response buffer with occupancy/empty/full status.
// Storage is cleared on reset so the read port presents zero while empty after reset.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [OW-1:0]    occupancy,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (occupancy == '0);
  assign full     = (occupancy == OW'(DEPTH));
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (rd_en) begin
      rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// alu_issue_ctrl: valid/ready command front end for the registered 32-bit ripple ALU,
// returning tagged, flag-masked results in order through a credit-protected FIFO.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_src1,
  input  logic [31:0]      cmd_src2,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int CNT_W   = $clog2(DEPTH + 4);
  localparam int ENTRY_W = $bits(rsp_data_t) + TAG_W;

  logic             cmd_fire;

  logic             v1;
  logic [TAG_W-1:0] tag1;
  logic [2:0]       op1;
  logic             err1;

  logic             v2;
  logic [TAG_W-1:0] tag2;
  logic [2:0]       op2;
  logic             err2;

  logic             v_cap;
  rsp_data_t        cap_data;
  logic [TAG_W-1:0] cap_tag;

  logic [ENTRY_W-1:0] fifo_in;
  logic [ENTRY_W-1:0] fifo_out;
  logic [OCC_W-1:0]   fifo_occ;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;
  rsp_data_t          head;
  logic [CNT_W-1:0]   credit_cnt;

  // Every accepted command owns a slot from acceptance until it leaves the FIFO,
  // so the capture stage can never find the FIFO full. Pops are not credited
  // back until they show up in registered occupancy.
  assign credit_cnt = CNT_W'(fifo_occ) + CNT_W'(v1) + CNT_W'(v2) + CNT_W'(v_cap);
  assign cmd_ready  = (credit_cnt < CNT_W'(DEPTH));
  assign cmd_fire   = cmd_valid & cmd_ready;

  // S1: operand/control registers double as the ALU input drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src1 <= '0;
      alu_src2 <= '0;
      alu_ctrl <= CTRL_AND;
      v1       <= 1'b0;
      tag1     <= '0;
      op1      <= '0;
      err1     <= 1'b0;
    end else begin
      v1 <= cmd_fire;
      if (cmd_fire) begin
        alu_src1 <= cmd_src1;
        alu_src2 <= cmd_src2;
        alu_ctrl <= op_to_ctrl(cmd_op);
        tag1     <= cmd_tag;
        op1      <= cmd_op;
        err1     <= op_is_illegal(cmd_op);
      end
    end
  end

  // S2: tracks the ALU's internal result register, which loads on this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      tag2 <= '0;
      op2  <= '0;
      err2 <= 1'b0;
    end else begin
      v2   <= v1;
      tag2 <= tag1;
      op2  <= op1;
      err2 <= err1;
    end
  end

  // Capture: ALU outputs are only trusted when a valid command is aligned with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_cap    <= 1'b0;
      cap_data <= '0;
      cap_tag  <= '0;
    end else begin
      v_cap <= v2;
      if (v2) begin
        cap_data.result <= alu_result;
        cap_data.zero   <= alu_zero;
        cap_data.cout   <= alu_cout & op_has_flags(op2);
        cap_data.ovf    <= alu_overflow & op_has_flags(op2);
        cap_data.err    <= err2;
        cap_tag         <= tag2;
      end
    end
  end

  assign fifo_in  = {cap_data, cap_tag};
  assign fifo_pop = rsp_valid & rsp_ready;

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (v_cap),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .occupancy (fifo_occ),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign {head, rsp_tag} = fifo_out;
  assign rsp_valid  = ~fifo_empty;
  assign rsp_result = head.result;
  assign rsp_zero   = head.zero;
  assign rsp_cout   = head.cout;
  assign rsp_ovf    = head.ovf;
  assign rsp_err    = head.err;

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(v_cap && fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// tb_alu_issue_ctrl: randomized and directed stimulus with a queue scoreboard; includes
// a behavioural registered ALU so the front end sees realistic one-cycle latency.
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_src1;
  logic [31:0]      cmd_src2;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      alu_src1;
  logic [31:0]      alu_src2;
  logic [3:0]       alu_ctrl;
  logic [31:0]      alu_result = 32'hDEAD_BEEF;
  logic             alu_zero = 1'b0;
  logic             alu_cout = 1'b1;
  logic             alu_overflow = 1'b1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_cout;
  logic             rsp_ovf;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  typedef struct packed {
    logic [31:0]      r;
    logic             z;
    logic             c;
    logic             o;
    logic             e;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_bp = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_src1     (cmd_src1),
    .cmd_src2     (cmd_src2),
    .cmd_tag      (cmd_tag),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_cout     (rsp_cout),
    .rsp_ovf      (rsp_ovf),
    .rsp_err      (rsp_err),
    .rsp_tag      (rsp_tag)
  );

  // Ripple ALU stand-in: registered outputs, no reset, adder flags always produced.
  always @(posedge clk) begin : alu_model
    logic [31:0] a, b, r;
    logic [32:0] s;
    a = alu_ctrl[3] ? ~alu_src1 : alu_src1;
    b = alu_ctrl[2] ? ~alu_src2 : alu_src2;
    s = {1'b0, a} + {1'b0, b} + {32'b0, alu_ctrl[2]};
    case (alu_ctrl[1:0])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = s[31:0];
      default: r = {31'b0, s[31]};
    endcase
    alu_result   <= r;
    alu_zero     <= (r == 32'd0);
    alu_cout     <= s[32];
    alu_overflow <= (a[31] == b[31]) && (s[31] != a[31]);
  end

  // Reference: what the consumer should see for a command, from the opcode semantics.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag);
    exp_t        x;
    logic [32:0] s;
    logic [31:0] d;
    x = '0;
    x.tag = tag;
    case (op)
      3'd0: x.r = a & b;
      3'd1: x.r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        x.r = s[31:0];
        x.c = s[32];
        x.o = (a[31] == b[31]) && (x.r[31] != a[31]);
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        x.r = s[31:0];
        x.c = s[32];
        x.o = (a[31] != b[31]) && (x.r[31] != a[31]);
      end
      3'd4: begin
        d = a - b;
        x.r = {31'b0, d[31]};
      end
      3'd5: x.r = ~(a | b);
      default: begin
        x.r = a & b;
        x.e = 1'b1;
      end
    endcase
    x.z = (x.r == 32'd0);
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Scoreboard producer: one expected entry per accepted command.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready)
      exp_q.push_back(model(cmd_op, cmd_src1, cmd_src2, cmd_tag));
  end

  // Monitor: compare on every response handshake, and check stability while stalled.
  exp_t got_v;
  exp_t hold_v;
  bit   stall_prev = 1'b0;
  always @(negedge clk) begin
    got_v = {rsp_result, rsp_zero, rsp_cout, rsp_ovf, rsp_err, rsp_tag};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (rsp_valid && stall_prev) begin
        vectors++;
        if (got_v !== hold_v) begin
          miscompares++;
          $display("FAIL rsp_hold: got %h expected %h", got_v, hold_v);
        end
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got %h expected no response", got_v);
        end else begin
          exp_t w;
          w = exp_q.pop_front();
          if (got_v !== w) begin
            miscompares++;
            $display("FAIL rsp tag=%0d: got %h expected %h", w.tag, got_v, w);
          end
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      hold_v = got_v;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int max_wait, output bit acc);
    cmd_op = op;
    cmd_src1 = a;
    cmd_src2 = b;
    cmd_tag = tag;
    cmd_valid = 1'b1;
    acc = 1'b0;
    for (int w = 0; w < max_wait && !acc; w++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    rsp_ready = 1'b1;
    for (int w = 0; w < 300 && !done; w++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit acc;
    int lat;
    int n_acc;
    bit stale;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_src1 = '0;
    cmd_src2 = '0;
    cmd_tag = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", {rsp_result, rsp_zero, rsp_cout, rsp_ovf, rsp_err, rsp_tag}, 64'd0);
    chk("reset_alu_src", {alu_src1, alu_src2}, 64'd0);
    chk("reset_alu_ctrl", 64'(alu_ctrl), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);

    // ADD 7+5 with latency measurement from the accepting edge.
    issue(3'd2, 32'd7, 32'd5, 4'd3, 10, acc);
    chk("add_accept", 64'(acc), 64'd1);
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    drain("add");

    // Flag and opcode corner cases, issued back to back.
    issue(3'd3, 32'd5, 32'd5, 4'd1, 10, acc);
    issue(3'd2, 32'h7FFF_FFFF, 32'd1, 4'd2, 10, acc);
    issue(3'd4, 32'hFFFF_FFFE, 32'd1, 4'd4, 10, acc);
    issue(3'd5, 32'd0, 32'd0, 4'd5, 10, acc);
    issue(3'd7, 32'hF0, 32'h0F, 4'd6, 10, acc);
    issue(3'd6, 32'hFF, 32'h3C, 4'd7, 10, acc);
    drain("corners");

    // Streaming with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      issue(3'($urandom_range(0, 5)), pick_operand(), pick_operand(), 4'(i), 20, acc);
      chk("stream_accept", 64'(acc), 64'd1);
    end
    drain("stream");

    // Backpressure: only DEPTH commands fit.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      issue(3'd2, 32'(i), 32'(i), 4'(i), 4, acc);
      n_acc += int'(acc);
    end
    chk("bp_accepted", 64'(n_acc), 64'(DEPTH));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    drain("bp");

    // Reset with two in flight and one buffered.
    rsp_ready = 1'b0;
    issue(3'd2, 32'd10, 32'd20, 4'd9, 10, acc);
    issue(3'd1, 32'd3, 32'd4, 4'd10, 10, acc);
    issue(3'd0, 32'hFF, 32'h0F, 4'd11, 10, acc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_rsp_valid", 64'(rsp_valid), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) stale = 1'b1;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);
    issue(3'd2, 32'd1, 32'd1, 4'd12, 10, acc);
    drain("post_reset");

    // Randomized traffic with random consumer backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 4'($urandom), 100, acc);
      chk("rand_accept", 64'(acc), 64'd1);
    end
    rand_bp = 1'b0;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
